// File: rtl/alu_issue_stage.sv
// Operand-issue / execute / writeback stage that feeds an external combinational ALU.
// Operands come from a local register file with forwarding from the EX and WB registers.
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             in_imm_en,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_rd,
  input  logic [2:0]       alu_flag,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [2:0]       wb_flag,
  output logic             err_illegal
);

  logic [WIDTH-1:0] r_regs [NREG];

  logic             r_exValid;
  logic [AW-1:0]    r_exRd;
  logic [WIDTH-1:0] r_aluRs1;
  logic [WIDTH-1:0] r_aluRs2;
  logic [3:0]       r_aluOp;

  logic             r_wbValid;
  logic [AW-1:0]    r_wbAddr;
  logic [WIDTH-1:0] r_wbData;
  logic [2:0]       r_wbFlag;
  logic             r_errIllegal;

  logic             w_wbAdv;
  logic             w_exAdv;
  logic             w_inReady;
  logic             w_accept;
  logic             w_commit;
  logic             w_exFwd;
  logic             w_wbFwd;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2Reg;
  logic [WIDTH-1:0] w_op2;

  assign w_wbAdv   = !r_wbValid || wb_ready;
  assign w_exAdv   = r_exValid && w_wbAdv;
  assign w_inReady = !r_exValid || w_wbAdv;
  assign w_accept  = in_valid && w_inReady;
  assign w_commit  = r_wbValid && wb_ready && !r_wbFlag[2] && (r_wbAddr != '0);

  // Illegal results and writes to r0 never act as forwarding sources.
  assign w_exFwd = r_exValid && (r_exRd != '0) && !alu_flag[2];
  assign w_wbFwd = r_wbValid && (r_wbAddr != '0) && !r_wbFlag[2];

  always_comb begin
    w_op1 = r_regs[in_rs1];
    if (w_exFwd && (r_exRd == in_rs1)) begin
      w_op1 = alu_rd;
    end else if (w_wbFwd && (r_wbAddr == in_rs1)) begin
      w_op1 = r_wbData;
    end
  end

  always_comb begin
    w_op2Reg = r_regs[in_rs2];
    if (w_exFwd && (r_exRd == in_rs2)) begin
      w_op2Reg = alu_rd;
    end else if (w_wbFwd && (r_wbAddr == in_rs2)) begin
      w_op2Reg = r_wbData;
    end
  end

  assign w_op2 = in_imm_en ? in_imm : w_op2Reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exValid <= 1'b0;
      r_exRd    <= '0;
      r_aluRs1  <= '0;
      r_aluRs2  <= '0;
      r_aluOp   <= '0;
    end else if (w_inReady) begin
      r_exValid <= in_valid;
      if (w_accept) begin
        r_exRd   <= in_rd;
        r_aluRs1 <= w_op1;
        r_aluRs2 <= w_op2;
        r_aluOp  <= in_op;
      end
    end
  end

  // WB reloads on the same edge it drains, so a full pipe streams without bubbles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wbValid <= 1'b0;
      r_wbAddr  <= '0;
      r_wbData  <= '0;
      r_wbFlag  <= '0;
    end else if (w_wbAdv) begin
      r_wbValid <= r_exValid;
      if (w_exAdv) begin
        r_wbAddr <= r_exRd;
        r_wbData <= alu_rd;
        r_wbFlag <= alu_flag;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_errIllegal <= 1'b0;
    end else if (r_wbValid && wb_ready && r_wbFlag[2]) begin
      r_errIllegal <= 1'b1;
    end
  end

  // Entry 0 is never written, so it reads as zero for the life of the reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[r_wbAddr] <= r_wbData;
    end
  end

  assign in_ready    = w_inReady;
  assign alu_rs1     = r_aluRs1;
  assign alu_rs2     = r_aluRs2;
  assign alu_op      = r_aluOp;
  assign wb_valid    = r_wbValid;
  assign wb_addr     = r_wbAddr;
  assign wb_data     = r_wbData;
  assign wb_flag     = r_wbFlag;
  assign err_illegal = r_errIllegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: provides the ALU, keeps an in-order architectural model
// with an expected-retirement queue, and runs directed hazard/backpressure/reset scenarios.
module tb_alu_issue_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic        in_imm_en;
  logic [15:0] in_imm;
  logic [15:0] alu_rs1;
  logic [15:0] alu_rs2;
  logic [3:0]  alu_op;
  logic [15:0] alu_rd;
  logic [2:0]  alu_flag;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  wb_flag;
  logic        err_illegal;

  alu_issue_stage #(.WIDTH(16), .NREG(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op),
    .alu_rd(alu_rd), .alu_flag(alu_flag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_flag(wb_flag), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {flag, result}; flag = {illegal, negative, zero}.
  function automatic logic [18:0] aluRef(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        ill;
    r   = '0;
    ill = 1'b0;
    case (op)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  r = a & b;
      4'd4:  r = a << b[3:0];
      4'd5:  r = a >> b[3:0];
      4'd6:  r = 16'($signed(a) >>> b[3:0]);
      4'd7:  r = {15'd0, $signed(a) < $signed(b)};
      4'd8:  r = {15'd0, a < b};
      4'd9:  r = {{8{a[7]}}, a[7:0]};
      4'd10: r = {8'd0, a[7:0]};
      4'd11: r = a ^ b;
      4'd12: r = 16'(-a);
      default: ill = 1'b1;
    endcase
    return {ill, r[15], (r == 16'd0), r};
  endfunction

  always_comb begin
    {alu_flag, alu_rd} = aluRef(alu_op, alu_rs1, alu_rs2);
  end

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  flag;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  exp_t        retLog[$];
  logic [15:0] mreg [8];
  logic        errExp;
  int          cyc;
  int          acceptCount;
  int          total;
  int          bad;

  initial begin
    cyc = 0;
    acceptCount = 0;
    total = 0;
    bad = 0;
    errExp = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Compare process: checks outputs each cycle, then applies the transfers of the coming edge.
  always @(negedge clk) begin
    exp_t e;
    logic [18:0] res;
    logic [15:0] b;
    if (!resetn) begin
      q.delete();
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      errExp = 1'b0;
      checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      checkOutput("rst_err", {31'd0, err_illegal}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_alu", {12'd0, alu_op, alu_rs1}, 32'd0);
      checkOutput("rst_alu_rs2", {16'd0, alu_rs2}, 32'd0);
      checkOutput("rst_wb_fields", {10'd0, wb_addr, wb_flag, wb_data}, 32'd0);
    end else begin
      checkOutput("wb_valid", {31'd0, wb_valid},
                  {31'd0, (q.size() > 0) && (cyc >= q[0].stamp + 1)});
      if (wb_valid && q.size() > 0) begin
        checkOutput("wb_addr", {29'd0, wb_addr}, {29'd0, q[0].addr});
        checkOutput("wb_data", {16'd0, wb_data}, {16'd0, q[0].data});
        checkOutput("wb_flag", {29'd0, wb_flag}, {29'd0, q[0].flag});
      end
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !((q.size() >= 2) && !wb_ready)});
      checkOutput("err_illegal", {31'd0, err_illegal}, {31'd0, errExp});
      if (wb_valid && wb_ready && q.size() > 0) begin
        e = q.pop_front();
        e.stamp = cyc + 1;
        retLog.push_back(e);
        if (e.flag[2]) errExp = 1'b1;
      end
      if (in_valid && in_ready) begin
        b = in_imm_en ? in_imm : mreg[in_rs2];
        res = aluRef(in_op, mreg[in_rs1], b);
        e.addr = in_rd;
        e.data = res[15:0];
        e.flag = res[18:16];
        e.stamp = cyc + 1;
        q.push_back(e);
        if (!res[18] && in_rd != 3'd0) mreg[in_rd] = res[15:0];
        acceptCount++;
      end
    end
  end

  function automatic logic [31:0] logData(input int idx);
    if (idx < retLog.size()) return {16'd0, retLog[idx].data};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] logCyc(input int idx);
    if (idx < retLog.size()) return retLog[idx].stamp;
    return 32'hFFFF_FFFF;
  endfunction

  // Presents one instruction and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic immEn, input logic [15:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm_en = immEn;
    in_imm    = imm;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    checkOutput("issue_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drainPipe();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    checkOutput("drain_empty", q.size(), 32'd0);
  endtask

  // Reads a register without side effects by retiring ADD r0 = rX + 0.
  task automatic readReg(input string name, input logic [2:0] r, input logic [15:0] expected);
    int base;
    base = retLog.size();
    applyStimulus(4'd1, 3'd0, r, 3'd0, 1'b1, 16'd0);
    drainPipe();
    checkOutput(name, logData(base), {16'd0, expected});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int acc0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm_en = 1'b0;
    in_imm    = '0;
    wb_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] dependent chain");
    base = retLog.size();
    applyStimulus(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
    applyStimulus(4'd1, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0);
    applyStimulus(4'd2, 3'd3, 3'd2, 3'd0, 1'b1, 16'd3);
    drainPipe();
    checkOutput("chain_0", logData(base), 32'd5);
    checkOutput("chain_1", logData(base + 1), 32'd10);
    checkOutput("chain_2", logData(base + 2), 32'd7);
    checkOutput("chain_gap1", logCyc(base + 1) - logCyc(base), 32'd1);
    checkOutput("chain_gap2", logCyc(base + 2) - logCyc(base + 1), 32'd1);
    readReg("chain_r3", 3'd3, 16'd7);

    $display("[TB] backpressure");
    base = retLog.size();
    acc0 = acceptCount;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          applyStimulus(4'd1, 3'(k), 3'd0, 3'd0, 1'b1, 16'h0100 + 16'(k));
        end
      end
      begin
        wb_ready = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("stall_accepts", acceptCount - acc0, 32'd2);
        #1;
        wb_ready = 1'b1;
      end
    join
    drainPipe();
    checkOutput("stall_count", retLog.size() - base, 32'd6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("stall_data", logData(base + k), 32'h0101 + 32'(k));
      if (k > 0) checkOutput("stall_rate", logCyc(base + k) - logCyc(base + k - 1), 32'd1);
    end

    $display("[TB] register zero");
    base = retLog.size();
    applyStimulus(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);
    applyStimulus(4'd1, 3'd4, 3'd0, 3'd0, 1'b0, 16'd0);
    drainPipe();
    checkOutput("r0_first", logData(base), 32'h1234);
    checkOutput("r0_second", logData(base + 1), 32'd0);
    readReg("r0_r4", 3'd4, 16'd0);

    $display("[TB] illegal opcode");
    applyStimulus(4'd1, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9);
    drainPipe();
    base = retLog.size();
    applyStimulus(4'd15, 3'd5, 3'd0, 3'd0, 1'b1, 16'd7);
    applyStimulus(4'd1, 3'd6, 3'd5, 3'd0, 1'b0, 16'd0);
    drainPipe();
    checkOutput("ill_flag", (base < retLog.size()) ? {31'd0, retLog[base].flag[2]} : 32'hFFFF_FFFF, 32'd1);
    checkOutput("ill_r6", logData(base + 1), 32'd9);
    readReg("ill_r5", 3'd5, 16'd9);
    readReg("ill_r6_rf", 3'd6, 16'd9);
    checkOutput("ill_sticky", {31'd0, err_illegal}, 32'd1);

    $display("[TB] sign fill via EX forwarding");
    base = retLog.size();
    applyStimulus(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'd1);
    applyStimulus(4'd12, 3'd7, 3'd1, 3'd0, 1'b0, 16'd0);
    applyStimulus(4'd6, 3'd7, 3'd7, 3'd0, 1'b1, 16'd4);
    drainPipe();
    checkOutput("neg_r7", logData(base + 1), 32'hFFFF);
    checkOutput("sra_r7", logData(base + 2), 32'hFFFF);
    checkOutput("ill_sticky_late", {31'd0, err_illegal}, 32'd1);

    $display("[TB] reset with work in flight");
    wb_ready = 1'b0;
    applyStimulus(4'd1, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0055);
    applyStimulus(4'd1, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0066);
    base = retLog.size();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("async_err", {31'd0, err_illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_no_retire", retLog.size() - base, 32'd0);
    for (int r = 1; r < 8; r++) begin
      readReg("rst_reg_zero", 3'(r), 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage wrapped around the combinational ALUsimple. Accepts one ALU instruction per cycle over a valid/ready handshake and reads operands from an internal NREG-entry register file, forwarding from in-flight results. It drives the ALU through an execute register, captures the ALU result into a writeback register, and retires through a second valid/ready handshake that commits to the register file.

## Interface
- WIDTH, 16, datapath width; must match the ALU's WIDTH.
- NREG, 8, register count; AW = $clog2(NREG).
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset; also drives the ALU's resetn.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- in_op  in  4  ALU opcode.
- in_rd, in_rs1, in_rs2  in  AW each  destination and source register indices.
- in_imm_en  in  1  use in_imm instead of register rs2.
- in_imm  in  WIDTH  immediate operand.
- alu_rs1, alu_rs2  out  WIDTH each  execute-register operands to the ALU.
- alu_op  out  4  execute-register opcode to the ALU.
- alu_rd  in  WIDTH  ALU result (combinational from alu_*).
- alu_flag  in  3  ALU flags; bit 2 = illegal opcode.
- wb_valid  out  1  writeback register holds a retiring result.
- wb_ready  in  1  consumer accepts retirement.
- wb_addr  out  AW  destination index.
- wb_data  out  WIDTH  result.
- wb_flag  out  3  captured ALU flags.
- err_illegal  out  1  sticky; set on retirement of any illegal op.

## Operation
- Opcodes: ADD=1, SUB=2, AND=3, SLL=4, SRL=5, SRA=6, SLT=7, SLTU=8, SEXT=9, ZEXT=10, XOR=11, NEG=12. Any other value is illegal, as reported by alu_flag[2]. This stage never decodes the opcode itself.
- Pipeline: ISSUE (operand select) -> EX register (ex_valid, ex_rd, alu_*) -> WB register (wb_valid, wb_*) -> register-file commit.
- Handshakes: wb_adv = !wb_valid || wb_ready; ex_adv = ex_valid && wb_adv; in_ready = !ex_valid || wb_adv. Transfer happens only when valid && ready.
- Operand read at accept, by priority:
  - 1: EX result. Used when ex_valid, ex_rd == src, ex_rd != 0, and !alu_flag[2]; the value is alu_rd.
  - 2: WB register. Used when wb_valid, wb_addr == src, wb_addr != 0, and !wb_flag[2].
  - 3: register file.
- rs2 is replaced by in_imm when in_imm_en = 1.
- Register 0 always reads 0; writes to it are discarded.
- Commit: regfile[wb_addr] <= wb_data on wb_valid && wb_ready && !wb_flag[2] && wb_addr != 0.
- Illegal op: flows through the pipeline and retires normally with wb_flag[2] = 1. No register-file write; never a forwarding source. err_illegal is set at that retirement.
- Every bubble drops ex_valid/wb_valid; data registers hold their previous values.

## Timing
- Reset (async assert, sync release): ex_valid, wb_valid, err_illegal = 0. alu_rs1, alu_rs2, alu_op, wb_addr, wb_data, wb_flag = 0. All registers = 0. in_ready = 1.
- Reset mid-operation: in-flight instructions are dropped and none commits.
- Latency: accepted at edge N -> alu_* valid in cycle N+1 -> wb_valid in cycle N+2 -> register file updated at the first edge ≥ N+2 where wb_ready = 1.
- Throughput: 1 instruction/cycle when wb_ready = 1.
- Backpressure: with wb_ready = 0 and both stages full, in_ready = 0. alu_* and wb_* hold stable until wb_ready rises.
- Back-to-back dependent instructions need no stall; forwarding covers distance 1 (EX) and distance 2 (WB, including while stalled).
- A commit and a read of the same register in one cycle return the new value via WB forwarding.
- Simultaneous WB drain and EX advance: the WB register reloads in the same edge; there is no bubble.

## Test plan
- Seed r1 = 5 (ADD r1 = r0 + imm 5). Then ADD r2 = r1 + r1, then SUB r3 = r2 - imm 3, all back-to-back. Required: wb_data sequence 5, 10, 7 on consecutive cycles; final r3 = 7.
- Hold wb_ready = 0 for 4 cycles during an issue stream. Required: in_ready drops after 2 accepts, wb_* stable, nothing lost or duplicated; stream resumes at 1/cycle once wb_ready = 1.
- Issue ADD r0 = imm 0x1234 + r0, then ADD r4 = r0 + r0. Required: r0 reads 0, and wb_data = 0 for the second op.
- Issue op 4'b1111 to rd = r5 (r5 = 9), then ADD r6 = r5 + r0. Required: first retirement has wb_flag[2] = 1, r5 stays 9, r6 = 9, err_illegal = 1 until reset.
- Assert resetn low with 2 instructions in flight. Required: wb_valid, ex_valid and err_illegal drop immediately; no commit occurs; all registers read 0 afterwards.
- Issue NEG r7 = r1 (r1 = 1), then SRA r7 = r7 by imm 4. Required: wb_data 0xFFFF, then 0xFFFF, forwarded from EX.
